// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the boot-time program loader and the core it feeds.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    LEN   = 3'd0,
    DATA  = 3'd1,
    CSUM  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam int DEF_SIZE        = 8;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_HOLD_CYCLES = 4;

  // Largest payload that fits the instruction memory.
  function automatic int max_len(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Loads a framed (length, payload, checksum) image into instruction memory, holding the CPU in reset.
// Writes land one clock after each accepted byte; in_ready is registered and low outside LEN/DATA/CSUM.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int SIZE        = DEF_SIZE,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [SIZE-1:0]   in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SIZE-1:0]   mem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              error
);

  // Length compare is done wide enough to hold both the byte and the memory limit.
  localparam int CW = ((SIZE > ADDR_W) ? SIZE : ADDR_W) + 1;
  localparam int LW = ADDR_W + 1;
  localparam logic [CW-1:0] MAX_LEN = CW'(max_len(ADDR_W));

  state_t          state;
  logic [LW-1:0]   len;
  logic [LW-1:0]   count;
  logic [SIZE-1:0] sum;
  logic [7:0]      hold;

  logic            xfer;
  logic [CW-1:0]   byte_w;
  logic [LW-1:0]   count_nx;

  assign xfer     = in_valid & in_ready;
  assign byte_w   = CW'(in_data);
  assign count_nx = count + LW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= LEN;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rstn  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      len       <= '0;
      count     <= '0;
      sum       <= '0;
      hold      <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN: begin
          in_ready <= 1'b1;
          if (xfer) begin
            count <= '0;
            sum   <= '0;
            len   <= LW'(in_data);
            if (byte_w > MAX_LEN) begin
              state    <= ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if (in_data == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_wdata <= in_data;
            sum       <= sum + in_data;
            count     <= count_nx;
            if (count_nx == len) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state <= HOLD;
              hold  <= 8'(HOLD_CYCLES);
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Leaving on the count-of-one cycle makes the release land HOLD_CYCLES after the checksum.
          if (hold <= 8'd1) begin
            state    <= DONE;
            cpu_rstn <= 1'b1;
            done     <= 1'b1;
          end else begin
            hold <= hold - 8'd1;
          end
        end
        DONE, ERROR: begin
          if (reload) begin
            state    <= LEN;
            in_ready <= 1'b1;
            cpu_rstn <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            count    <= '0;
            sum      <= '0;
          end
        end
        default: begin
          state    <= LEN;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized frames checked against a frame-level reference model.
module tb_prog_loader;

  localparam int HOLD = 4;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       reload = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rstn;
  logic       done;
  logic       error;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int cyc = 0;
  int acc_edge = -1;
  logic last_acc = 1'b0;

  int rise_edge = -1;
  logic prev_cpu = 1'b0;
  int we_bad = 0;
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int wc_q[$];
  logic [7:0] shadow[256];

  prog_loader #(.SIZE(8), .ADDR_W(8), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rstn(cpu_rstn), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_acc <= in_valid && in_ready;
    if (in_valid && in_ready) acc_edge <= cyc;
  end

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
      shadow[mem_addr] = mem_wdata;
      if (!last_acc) we_bad++;
    end
    if (cpu_rstn && !prev_cpu) rise_edge = cyc - 1;
    prev_cpu = cpu_rstn;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // mode 0: continuous, 1: valid every other cycle, 2: random valid
  task automatic send(input bq_t f, input int mode, input string tag);
    int i = 0;
    int guard = 0;
    logic v;
    logic acc;
    while (i < f.size() && guard < 2000) begin
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? f[i] : 8'($urandom);
      acc = v && in_ready;
      tick();
      if (acc) i++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (guard >= 2000) chk({tag, "_send_timeout"}, 32'(i), 32'(f.size()));
  endtask

  task automatic pulse_reload(input string tag);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk({tag, "_rl_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_rl_flags"}, {29'b0, done, error, cpu_rstn}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_we"},    {31'b0, mem_we}, 32'd0);
    chk({tag, "_addr"},  {24'b0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'b0, mem_wdata}, 32'd0);
    chk({tag, "_flags"}, {29'b0, cpu_rstn, done, error}, 32'd0);
  endtask

  task automatic run_frame(input bq_t f, input int mode, input string tag);
    int len;
    int s = 0;
    int bad = 0;
    int t = 0;
    logic good;
    len = int'(f[0]);
    for (int k = 1; k <= len; k++) s += int'(f[k]);
    good = (8'(s) == f[len+1]);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    we_bad = 0;
    rise_edge = -1;
    send(f, mode, tag);
    while (!(done || error) && t < 40) begin
      tick();
      t++;
    end
    tick();
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(len));
    for (int k = 0; k < wa_q.size() && k < len; k++) begin
      if (wa_q[k] != 8'(k) || wd_q[k] != f[k+1]) bad++;
      if (mode == 0 && k > 0 && wc_q[k] - wc_q[k-1] != 1) bad++;
    end
    chk({tag, "_writes"}, 32'(bad), 32'd0);
    chk({tag, "_done"},     {31'b0, done}, {31'b0, good});
    chk({tag, "_error"},    {31'b0, error}, {31'b0, ~good});
    chk({tag, "_cpu_rstn"}, {31'b0, cpu_rstn}, {31'b0, good});
    if (good) chk({tag, "_hold"}, 32'(rise_edge - acc_edge), 32'(HOLD));
    chk({tag, "_ready_off"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_we_follow"}, 32'(we_bad), 32'd0);
  endtask

  initial begin
    bq_t f;
    int n;
    int s;

    // reset and release
    repeat (3) tick();
    check_reset_vals("rst");
    rstn = 1'b1;
    chk("rst_ready_low_at_release", {31'b0, in_ready}, 32'd0);
    tick();
    chk("rst_ready_rise", {31'b0, in_ready}, 32'd1);

    f = {8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_frame(f, 0, "c1");
    pulse_reload("c1");
    run_frame(f, 1, "c2");

    pulse_reload("c2");
    run_frame({8'h02, 8'h10, 8'h20, 8'h31}, 0, "c3");
    pulse_reload("c3");
    run_frame({8'h01, 8'h7F, 8'h7F}, 0, "c3b");
    chk("c3b_mem0", {24'b0, shadow[0]}, 32'h7F);

    pulse_reload("c3b");
    run_frame({8'h00, 8'h00}, 0, "c4");
    pulse_reload("c4");
    run_frame({8'h00, 8'h05}, 0, "c4b");

    pulse_reload("c4b");
    run_frame({8'h02, 8'hFF, 8'h02, 8'h01}, 0, "c5");

    // abort after the second payload byte
    pulse_reload("c5");
    send({8'h03, 8'h11, 8'h22}, 0, "c6a");
    chk("c6_mid_we", {31'b0, mem_we}, 32'd1);
    #2 rstn = 1'b0;
    #1 check_reset_vals("c6_async");
    tick();
    rstn = 1'b1;
    tick();
    run_frame(f, 0, "c6");
    chk("c6_mem", {8'b0, shadow[0], shadow[1], shadow[2]}, 32'h112233);

    for (int r = 0; r < 15; r++) begin
      pulse_reload("rnd");
      n = $urandom_range(0, 12);
      s = 0;
      f = {8'(n)};
      for (int k = 0; k < n; k++) begin
        f.push_back(8'($urandom));
        s += int'(f[k+1]);
      end
      if ($urandom_range(0, 3) == 0) f.push_back(8'(s) ^ 8'($urandom_range(1, 255)));
      else f.push_back(8'(s));
      run_frame(f, 2, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader upstream of top_level.
- After reset it receives a framed byte stream (length, payload, checksum) over a valid/ready interface and writes the payload into the CPU instruction memory.
- It holds the CPU in reset until the image is loaded and verified.
- The CPU sees only cpu_rstn and a populated memory.

Parameters:
SIZE, 8, data/byte width; matches top_level SIZE
ADDR_W, 8, instruction memory address width; max payload 2^ADDR_W-1 words
HOLD_CYCLES, 4, cycles cpu_rstn stays low after successful checksum (1..255)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
in_valid  input  1  stream byte valid
in_data  input  SIZE  stream byte
in_ready  output  1  loader accepts byte this cycle
reload  input  1  single-cycle pulse; restart load from DONE or ERROR
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_W  write address
mem_wdata  output  SIZE  write data
cpu_rstn  output  1  CPU reset, active-low
done  output  1  image loaded, checksum good, CPU released
error  output  1  checksum mismatch or length overflow

Behaviour:
- Interface: one clock clk; reset rstn is asynchronous, active-low. Everything else is synchronous to rising clk.
- Reset values: state=LEN, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rstn=0, done=0, error=0, count=0, sum=0. in_ready rises the first clock after rstn deasserts.
- Transfer occurs when in_valid && in_ready; one byte per cycle max. in_valid may drop at any time with no effect.
- in_ready=1 only in LEN, DATA, CSUM.
- LEN: accepted byte -> len.
  - If len > 2^ADDR_W-1 (only possible when SIZE>ADDR_W): go to ERROR.
  - If len==0: go to CSUM.
  - Otherwise: go to DATA with count=0, sum=0.
- DATA: each accepted byte registers mem_we=1, mem_addr=count, mem_wdata=in_data on the next clock (1-cycle latency).
  - sum += byte mod 2^SIZE; count++.
  - After the len-th byte, go to CSUM.
  - mem_we is deasserted in any cycle with no accept.
- CSUM: accepted byte compared with sum (len==0 expects 0).
  - Match: go to HOLD with hold counter loaded with HOLD_CYCLES.
  - Mismatch: go to ERROR.
- HOLD: counter decrements each cycle; at 0 go to DONE.
- DONE: cpu_rstn=1 and done=1 from the first DONE cycle. Memory writes are impossible.
- ERROR: error=1, cpu_rstn=0, in_ready=0. Memory contents are undefined.
- reload in DONE or ERROR: next cycle returns to LEN.
  - cpu_rstn=0, done=0, error=0; count and sum cleared.
  - reload in any other state is ignored.
- Payload write addresses start at 0 every load. Widen count to ADDR_W+1 bits internally so len=2^ADDR_W-1 terminates correctly with no wrap.
- rstn assertion mid-load aborts immediately to the reset values. A partial image is left in memory and is overwritten by the next load.
- in_data is ignored when no transfer occurs.

Decomposition:
- Package prog_loader_pkg:
  - state enum: LEN, DATA, CSUM, HOLD, DONE, ERROR.
  - Default SIZE and ADDR_W constants shared with top_level.
- No sub-module required. The hold counter is inline.

Test Plan:
1. Reset then stream 03,11,22,33,66 continuously:
   - mem writes (0,11),(1,22),(2,33) on consecutive cycles.
   - cpu_rstn rises 4 cycles after the checksum accept; done=1, error=0.
2. Same frame with in_valid toggled every other cycle:
   - identical writes and final state.
   - mem_we never high in a cycle following a non-accept.
3. Stream 02,10,20,31:
   - two writes, then error=1, cpu_rstn stays 0.
   - Pulse reload, send 01,7F,7F: done=1, mem[0]=7F.
4. Stream 00,00:
   - no mem writes; done after HOLD_CYCLES.
   - Stream 00,05 instead: error=1.
5. Checksum wrap: 02,FF,02 then checksum 01:
   - done=1 (sum mod 256).
6. Assert rstn low after the second payload byte of case 1:
   - all outputs return to reset values asynchronously.
   - Re-stream case 1: done=1 and mem contents correct.
